// File: rtl/usb2classic_pkg.sv
// -----------------------------------------------------------------------------
// usb2classic_pkg
// Shared types and default constants for the classic-controller blocks.
// Holds the 3DO reader FSM state enum, its default timing constants and a
// small integer helper used to size the reader's counters.
// -----------------------------------------------------------------------------
package usb2classic_pkg;

    // 3DO reader frame sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } threedeeo_rd_state_t;

    // Default frame geometry for the 3DO reader.
    localparam int THREEDEEO_BITS         = 16;
    localparam int THREEDEEO_LATCH_CYCLES = 8;
    localparam int THREEDEEO_HALF_CYCLES  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : usb2classic_pkg

// File: rtl/threedeeo_reader_if.sv
// -----------------------------------------------------------------------------
// threedeeo_reader_if
// Bundles the 3DO reader's request/port/result signals.
//   start : request one read frame            (system -> reader)
//   dat   : port DAT line from the pad         (pad    -> reader)
//   ps    : port PS/latch line                 (reader -> pad)
//   clk   : port serial clock                  (reader -> pad)
//   data  : last completed word, 1 = pressed   (reader -> system)
//   valid : one-cycle pulse when data updates  (reader -> system)
//   busy  : frame in progress                  (reader -> system)
// Modports: master = the reader, slave = the surrounding system and pad.
// -----------------------------------------------------------------------------
interface threedeeo_reader_if #(
    parameter int BITS = usb2classic_pkg::THREEDEEO_BITS
);
    logic            start;
    logic            dat;
    logic            ps;
    logic            clk;
    logic [BITS-1:0] data;
    logic            valid;
    logic            busy;

    modport master (
        input  start, dat,
        output ps, clk, data, valid, busy
    );

    modport slave (
        output start, dat,
        input  ps, clk, data, valid, busy
    );
endinterface : threedeeo_reader_if

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous input bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule : sync2

// File: rtl/threedeeo_reader.sv
// -----------------------------------------------------------------------------
// threedeeo_reader
// Host-side 3DO controller port reader. Drives PS high for LATCH_CYCLES,
// then clocks BITS serial bits (HALF_CYCLES low, HALF_CYCLES high each),
// sampling inverted DAT at the end of every low phase, MSB first. The
// finished word is published on data with a one-cycle valid pulse.
//   system_clock : sole clock, rising edge
//   reset_n      : asynchronous active-low reset
//   bus          : threedeeo_reader_if.master (start, dat, ps, clk, data,
//                  valid, busy)
// Optional feature: define THREEDEEO_DAT_SYNC_EN to pass dat through a
// 2-flop synchronizer (reset value 1) before sampling; HALF_CYCLES must then
// be at least 3.
// -----------------------------------------------------------------------------
module threedeeo_reader
    import usb2classic_pkg::*;
#(
    parameter int BITS         = THREEDEEO_BITS,
    parameter int LATCH_CYCLES = THREEDEEO_LATCH_CYCLES,
    parameter int HALF_CYCLES  = THREEDEEO_HALF_CYCLES
) (
    input  logic                 system_clock,
    input  logic                 reset_n,
    threedeeo_reader_if.master   bus
);
    // Counter widths cover the largest terminal count with one spare bit.
    localparam int CYC_W = $clog2(max_int(LATCH_CYCLES, HALF_CYCLES)) + 1;
    localparam int BIT_W = $clog2(BITS) + 1;

    localparam logic [CYC_W-1:0] LATCH_LAST = CYC_W'(LATCH_CYCLES - 1);
    localparam logic [CYC_W-1:0] HALF_LAST  = CYC_W'(HALF_CYCLES - 1);
    localparam logic [BIT_W-1:0] BITS_END   = BIT_W'(BITS);

    logic dat_s;

`ifdef THREEDEEO_DAT_SYNC_EN
    if (HALF_CYCLES < 3) begin : g_half_check
        $error("threedeeo_reader: HALF_CYCLES must be >= 3 with the DAT synchronizer");
    end

    // Idle DAT is high, so the synchronizer resets to 1 to avoid a
    // spurious "pressed" bit right after reset.
    sync2 #(.RESET_VAL(1'b1)) u_dat_sync (
        .clk   (system_clock),
        .rst_n (reset_n),
        .d     (bus.dat),
        .q     (dat_s)
    );
`else
    // Pad is assumed synchronous to system_clock (or DAT stable at the
    // sample edge), so DAT is used directly with no added latency.
    assign dat_s = bus.dat;
`endif

    threedeeo_rd_state_t state_q, state_d;
    logic [CYC_W-1:0]    cyc_q,   cyc_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic [BITS-1:0]     shift_q, shift_d;
    logic [BITS-1:0]     data_q,  data_d;
    logic                ps_q,    ps_d;
    logic                clk_q,   clk_d;
    logic                valid_q, valid_d;
    logic                busy_q,  busy_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ps_d    = ps_q;
        clk_d   = clk_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LATCH;
                    ps_d    = 1'b1;
                    busy_d  = 1'b1;
                    cyc_d   = '0;
                end
            end

            LATCH: begin
                if (cyc_q == LATCH_LAST) begin
                    state_d = LOW;
                    ps_d    = 1'b0;
                    cyc_d   = '0;
                    bit_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            LOW: begin
                if (cyc_q == HALF_LAST) begin
                    // Sample on the same edge that raises CLK: DAT has been
                    // settled for the whole low phase. Pad data is active-low.
                    state_d = HIGH;
                    clk_d   = 1'b1;
                    cyc_d   = '0;
                    shift_d = {shift_q[BITS-2:0], ~dat_s};
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            HIGH: begin
                if (cyc_q == HALF_LAST) begin
                    clk_d = 1'b0;
                    cyc_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (bit_q + 1'b1 == BITS_END) begin
                        // Outputs are registered, so publishing on entry
                        // makes data/valid visible during the DONE cycle.
                        state_d = DONE;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        state_d = LOW;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            DONE: begin
                // start is deliberately ignored here; a held start re-enters
                // LATCH after one IDLE cycle.
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                ps_d    = 1'b0;
                clk_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ps_q    <= 1'b0;
            clk_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ps_q    <= ps_d;
            clk_q   <= clk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ps    = ps_q;
    assign bus.clk   = clk_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule : threedeeo_reader

// File: tb/tb_threedeeo_reader.sv
// -----------------------------------------------------------------------------
// tb_threedeeo_reader
// Directed bench for threedeeo_reader with default geometry (16 bits,
// PS 8 cycles, CLK half-period 4 cycles, frame 137 cycles).
// A behavioural 3DO pad holds DAT high during PS, then presents ~word MSB
// first, advancing on each CLK fall.
// -----------------------------------------------------------------------------
module tb_threedeeo_reader;

    localparam int L     = 8;
    localparam int H     = 4;
    localparam int B     = 16;
    localparam int V_CYC = L + 2 * H * B;   // edge after E0 where valid pulses
    localparam int FRAME = V_CYC + 1;       // 137

    logic system_clock = 1'b0;
    logic reset_n      = 1'b0;

    threedeeo_reader_if #(.BITS(B)) bus ();

    threedeeo_reader #(
        .BITS         (B),
        .LATCH_CYCLES (L),
        .HALF_CYCLES  (H)
    ) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .bus          (bus.master)
    );

    always #5 system_clock = ~system_clock;

    // ---------------- pad model ----------------
    logic [B-1:0] pad_word = '0;
    logic         pad_en   = 1'b1;
    int           pad_idx  = 0;

    always @(posedge bus.ps)  pad_idx = 0;
    always @(negedge bus.clk) pad_idx = pad_idx + 1;

    assign bus.dat = (!pad_en || bus.ps || pad_idx > B - 1) ? 1'b1
                                                             : ~pad_word[B-1-pad_idx];

    int n_vec = 0;
    int n_err = 0;

    // Expected {ps, clk, valid, busy} at c edges after E0 of one frame.
    function automatic logic [3:0] exp_frame(input int c);
        logic [3:0] e;
        int t;
        e = 4'b0000;
        if (c >= 0 && c <= V_CYC) begin
            t = c - L;
            e[3] = (c < L);
            e[2] = (t >= 0) && (t < 2 * H * B) && ((t % (2 * H)) >= H);
            e[1] = (c == V_CYC);
            e[0] = 1'b1;
        end
        return e;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.start = 1'b0;
        reset_n   = 1'b0;
        #2;  // before the first rising edge
        n_vec++;
        if ({bus.ps, bus.clk, bus.valid, bus.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.ps, bus.clk, bus.valid, bus.busy});
        end
        n_vec++;
        if (bus.data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0000", bus.data);
        end
        repeat (3) @(negedge system_clock);
        reset_n = 1'b1;
        @(negedge system_clock);
        n_vec++;
        if ({bus.ps, bus.clk, bus.valid, bus.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b expected 0000",
                     {bus.ps, bus.clk, bus.valid, bus.busy});
        end
    endtask

    // One frame with full per-cycle shape check; optional start poke while busy.
    task automatic run_frame(input string name, input logic [B-1:0] word,
                             input logic [B-1:0] prev, input int poke);
        logic [3:0]   got;
        logic [3:0]   exp;
        logic [B-1:0] exp_data;
        logic         clk_prev;
        int           ps_hi;
        int           clk_rises;
        pad_word  = word;
        ps_hi     = 0;
        clk_rises = 0;
        clk_prev  = 1'b0;
        @(negedge system_clock);
        bus.start = 1'b1;
        @(posedge system_clock);   // E0
        #1;
        bus.start = 1'b0;
        for (int c = 0; c <= FRAME + 8; c++) begin
            if (c > 0) begin
                @(posedge system_clock);
                #1;
            end
            if (c == poke)     bus.start = 1'b1;
            if (c == poke + 1) bus.start = 1'b0;
            got      = {bus.ps, bus.clk, bus.valid, bus.busy};
            exp      = exp_frame(c);
            exp_data = (c >= V_CYC) ? word : prev;
            if (bus.ps) ps_hi++;
            if (bus.clk && !clk_prev) clk_rises++;
            clk_prev = bus.clk;
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s_shape c=%0d: got ps/clk/valid/busy=%b expected %b",
                         name, c, got, exp);
            end
            n_vec++;
            if (bus.data !== exp_data) begin
                n_err++;
                $display("FAIL %s_data c=%0d: got %h expected %h",
                         name, c, bus.data, exp_data);
            end
        end
        n_vec++;
        if (ps_hi !== L) begin
            n_err++;
            $display("FAIL %s_ps_width: got %0d expected %0d", name, ps_hi, L);
        end
        n_vec++;
        if (clk_rises !== B) begin
            n_err++;
            $display("FAIL %s_clk_pulses: got %0d expected %0d", name, clk_rises, B);
        end
    endtask

    task automatic test_pattern();
        run_frame("pattern_5a3c", 16'h5A3C, 16'h0000, -10);
    endtask

    task automatic test_start_while_busy();
        run_frame("start_busy", 16'h3C5A, 16'h5A3C, 50);
    endtask

    task automatic test_back_to_back();
        logic [3:0]   got;
        logic [3:0]   exp;
        logic [B-1:0] exp_data;
        pad_word = 16'hFFFF;
        @(negedge system_clock);
        bus.start = 1'b1;
        @(posedge system_clock);   // E0 of first frame
        #1;
        for (int c = 0; c <= 2 * (FRAME + 1) + 8; c++) begin
            if (c > 0) begin
                @(posedge system_clock);
                #1;
            end
            if (c == 200) bus.start = 1'b0;   // drop during frame two
            got      = {bus.ps, bus.clk, bus.valid, bus.busy};
            exp      = exp_frame(c) | exp_frame(c - (FRAME + 1));
            exp_data = (c >= V_CYC) ? 16'hFFFF : 16'h3C5A;
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL b2b_shape c=%0d: got ps/clk/valid/busy=%b expected %b",
                         c, got, exp);
            end
            n_vec++;
            if (bus.data !== exp_data) begin
                n_err++;
                $display("FAIL b2b_data c=%0d: got %h expected %h", c, bus.data, exp_data);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        pad_word = 16'h1234;
        @(negedge system_clock);
        bus.start = 1'b1;
        @(posedge system_clock);   // E0
        #1;
        bus.start = 1'b0;
        repeat (L + 2 * H * 7 + 2) @(posedge system_clock);   // inside bit 7
        #2;
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre_busy: got %b expected 1", bus.busy);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.ps, bus.clk, bus.valid, bus.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_ctrl: got %b expected 0000",
                     {bus.ps, bus.clk, bus.valid, bus.busy});
        end
        n_vec++;
        if (bus.data !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_data: got %h expected 0000", bus.data);
        end
        repeat (2) @(negedge system_clock);
        reset_n = 1'b1;
        repeat (FRAME) @(negedge system_clock);
        n_vec++;
        if ({bus.data, bus.busy, bus.valid} !== 18'h0) begin
            n_err++;
            $display("FAIL midreset_quiet: got data=%h busy=%b valid=%b expected 0000/0/0",
                     bus.data, bus.busy, bus.valid);
        end
        run_frame("after_reset_8001", 16'h8001, 16'h0000, -10);
    endtask

    task automatic test_no_pad();
        pad_en = 1'b0;
        run_frame("no_pad", 16'h0000, 16'h8001, -10);
        pad_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_pad();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_threedeeo_reader
